// File: rtl/seq_calc.sv
// rtl/seq_calc.sv - registered signed calculator with handshakes, accumulator and shift-add multiply
module seq_calc #(
    parameter  int W  = 16,
    localparam int SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   OP,
    input  logic         use_acc,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] R,
    output logic         ovf,
    output logic         ovf_sticky,
    output logic [W-1:0] acc
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_RSB = 3'b010;
    localparam logic [2:0] OP_ABA = 3'b011;
    localparam logic [2:0] OP_ABB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [2*W-1:0]   mcand_q, mcand_d, prod_q, prod_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     r_q, r_d, acc_q, acc_d;
    logic             ovf_q, ovf_d, sticky_q, sticky_d;

    logic [W-1:0]     a_sel, sum, dab, dba, exec_r;
    logic             exec_o;
    logic [2*W-1:0]   partial, sprod;
    logic             mul_o;
    logic             load_res;
    logic [W-1:0]     res_r;
    logic             res_o;

    // Unsigned magnitude; the most negative value maps to 2^(W-1), which still fits in W bits.
    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic is_min(input logic [W-1:0] v);
        return v[W-1] & ~(|v[W-2:0]);
    endfunction

    assign a_sel = use_acc ? acc_q : A;
    assign sum   = a_q + b_q;
    assign dab   = a_q - b_q;
    assign dba   = b_q - a_q;

    always_comb begin
        exec_r = '0;
        exec_o = 1'b0;
        case (op_q)
            OP_ADD: begin
                exec_r = sum;
                exec_o = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                exec_r = dab;
                exec_o = (a_q[W-1] != b_q[W-1]) && (dab[W-1] != a_q[W-1]);
            end
            OP_RSB: begin
                exec_r = dba;
                exec_o = (a_q[W-1] != b_q[W-1]) && (dba[W-1] != b_q[W-1]);
            end
            OP_ABA: begin
                exec_r = mag(a_q);
                exec_o = is_min(a_q);
            end
            OP_ABB: begin
                exec_r = mag(b_q);
                exec_o = is_min(b_q);
            end
            OP_SHR:  exec_r = $signed(a_q) >>> b_q[SW-1:0];
            default: ;
        endcase
    end

    // One multiplier bit per cycle; the last step is folded into the cycle that leaves MUL.
    assign partial = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign sprod   = neg_q ? (~partial + 1'b1) : partial;
    assign mul_o   = !((&sprod[2*W-1:W-1]) || ~(|sprod[2*W-1:W-1]));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        load_res = 1'b0;
        res_r    = '0;
        res_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d     = OP;
                    a_d      = a_sel;
                    b_d      = B;
                    mcand_d  = {{W{1'b0}}, mag(a_sel)};
                    mplier_d = mag(B);
                    prod_d   = '0;
                    neg_d    = a_sel[W-1] ^ B[W-1];
                    cnt_d    = '0;
                    state_d  = (OP == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                load_res = 1'b1;
                res_r    = exec_r;
                res_o    = exec_o;
                state_d  = S_DONE;
            end
            S_MUL: begin
                prod_d   = partial;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SW'(1);
                if (cnt_q == SW'(W - 1)) begin
                    load_res = 1'b1;
                    res_r    = sprod[W-1:0];
                    res_o    = mul_o;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (load_res) begin
            r_d   = res_r;
            ovf_d = res_o;
            if (op_q == OP_CLR) begin
                acc_d    = '0;
                sticky_d = 1'b0;
            end else begin
                acc_d    = res_r;
                sticky_d = sticky_q | res_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            r_q      <= '0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign R          = r_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;
    assign acc        = acc_q;

endmodule

// File: tb/tb_seq_calc.sv
// tb/tb_seq_calc.sv - randomized and directed checks of seq_calc against an arithmetic model
module tb_seq_calc;
    localparam int W  = 16;
    localparam int SW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   OP;
    logic         use_acc;
    logic [W-1:0] A, B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] R;
    logic         ovf;
    logic         ovf_sticky;
    logic [W-1:0] acc;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_acc = '0;
    logic         m_sticky = 1'b0;
    logic [W-1:0] exp_r = '0, exp_acc = '0;
    logic         exp_o = 1'b0, exp_sticky = 1'b0;
    logic         exp_pending = 1'b0;

    seq_calc #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .OP(OP),
        .use_acc(use_acc), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .R(R), .ovf(ovf), .ovf_sticky(ovf_sticky), .acc(acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Exact-integer model: results wrap to W bits, overflow means the true value does not fit.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic o);
        longint sa, sb, full, maxv, minv;
        int amt;
        logic [SW-1:0] sh;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        sh   = b[SW-1:0];
        amt  = int'(sh);
        case (op)
            3'd0: full = sa + sb;
            3'd1: full = sa - sb;
            3'd2: full = sb - sa;
            3'd3: full = (sa < 0) ? -sa : sa;
            3'd4: full = (sb < 0) ? -sb : sb;
            3'd5: full = sa * sb;
            3'd6: full = sa >>> amt;
            default: full = 0;
        endcase
        r = full[W-1:0];
        o = (op <= 3'd5) && (full > maxv || full < minv);
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            chk("valid_expected", {31'd0, exp_pending}, 32'd1);
            chk("R",          {16'd0, R},          {16'd0, exp_r});
            chk("ovf",        {31'd0, ovf},        {31'd0, exp_o});
            chk("acc",        {16'd0, acc},        {16'd0, exp_acc});
            chk("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, exp_sticky});
            chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic do_op(input logic [2:0] op, input bit ua, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input bit lit, input logic [W-1:0] lr, input logic lo);
        int lat;
        logic [W-1:0] aop;
        for (int i = 0; i < 8 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; OP = op; use_acc = ua; A = a; B = b;
        aop = ua ? m_acc : a;
        model(op, aop, b, exp_r, exp_o);
        if (op == 3'd7) begin
            exp_acc = '0; exp_sticky = 1'b0;
        end else begin
            exp_acc = exp_r; exp_sticky = m_sticky | exp_o;
        end
        m_acc = exp_acc; m_sticky = exp_sticky; exp_pending = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; OP = 3'($urandom); A = W'($urandom); B = W'($urandom); use_acc = 1'($urandom);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        lat = 0;
        for (int i = 1; i <= W + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk("latency", 32'(lat), (op == 3'd5) ? 32'(W) : 32'd1);
        if (lit) begin
            chk("R_literal",   {16'd0, R},   {16'd0, lr});
            chk("ovf_literal", {31'd0, ovf}, {31'd0, lo});
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom); OP = 3'($urandom); A = W'($urandom); B = W'($urandom);
            @(posedge clk); #1;
            chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; exp_pending = 1'b0;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready",  {31'd0, in_ready},  32'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return {1'b1, {(W-1){1'b0}}};
            1: return {1'b0, {(W-1){1'b1}}};
            2: return '0;
            3: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; OP = '0; use_acc = 1'b0; A = '0; B = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready",  {31'd0, in_ready},   32'd1);
        chk("rst_out_valid", {31'd0, out_valid},  32'd0);
        chk("rst_R",         {16'd0, R},          32'd0);
        chk("rst_ovf",       {31'd0, ovf},        32'd0);
        chk("rst_sticky",    {31'd0, ovf_sticky}, 32'd0);
        chk("rst_acc",       {16'd0, acc},        32'd0);

        do_op(3'd0, 0, 16'h7FFF, 16'h0001, 0, 1, 16'h8000, 1'b1);
        do_op(3'd5, 0, 16'hFFFD, 16'h0007, 0, 1, 16'hFFEB, 1'b0);
        do_op(3'd5, 0, 16'h0100, 16'h0100, 0, 1, 16'h0000, 1'b1);
        do_op(3'd3, 0, 16'h8000, 16'h1234, 0, 1, 16'h8000, 1'b1);
        do_op(3'd4, 0, 16'h0000, 16'hFFF6, 0, 1, 16'h000A, 1'b0);
        do_op(3'd6, 0, 16'h8000, 16'h0013, 5, 1, 16'hF000, 1'b0);
        do_op(3'd1, 0, 16'h0000, 16'h8000, 0, 1, 16'h8000, 1'b1);
        do_op(3'd0, 0, 16'h0005, 16'h0000, 0, 1, 16'h0005, 1'b0);
        do_op(3'd0, 1, 16'h1111, 16'h0003, 0, 1, 16'h0008, 1'b0);
        do_op(3'd7, 0, 16'h2222, 16'h3333, 0, 1, 16'h0000, 1'b0);

        // Reset lands in the 7th MUL cycle.
        in_valid = 1'b1; OP = 3'd5; use_acc = 1'b0; A = 16'h0123; B = 16'h0456;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = '0; m_sticky = 1'b0;
        chk("mrst_out_valid", {31'd0, out_valid},  32'd0);
        chk("mrst_in_ready",  {31'd0, in_ready},   32'd1);
        chk("mrst_acc",       {16'd0, acc},        32'd0);
        chk("mrst_sticky",    {31'd0, ovf_sticky}, 32'd0);
        chk("mrst_R",         {16'd0, R},          32'd0);
        do_op(3'd0, 0, 16'h0002, 16'h0002, 0, 1, 16'h0004, 1'b0);

        for (int n = 0; n < 150; n++) begin
            do_op(3'($urandom), 1'($urandom), pick(), pick(), $urandom_range(0, 3), 0, '0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_calc.md
Name: seq_calc

Overview:
- Registered, multi-cycle successor to the team's combinational signed calculator.
- Adds valid/ready handshakes on both sides, an internal accumulator that can replace operand A, an iterative shift-add signed multiply, an arithmetic shift, and a sticky overflow flag.
- Sits between a command source and a result consumer.
- Accepts one operation at a time and holds each result until the consumer takes it.

Parameters:
- W, 16, operand/result width in bits, two's complement, W >= 4.
- SW, $clog2(W), width of the shift-amount field taken from B (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  block can accept a command.
- OP  input  3  operation code.
- use_acc  input  1  1 = use the accumulator as operand A; input A is ignored.
- A  input  W  signed operand A.
- B  input  W  signed operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- R  output  W  signed result.
- ovf  output  1  overflow for the current result.
- ovf_sticky  output  1  OR of every ovf since the last reset or clear.
- acc  output  W  accumulator value.

Behaviour:
- Reset values, applied on the first edge with rst=1, including mid-operation: in_ready=1, out_valid=0, R=0, ovf=0, ovf_sticky=0, acc=0, FSM=IDLE. Any in-flight multiply is discarded.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1, latch OP, B, and the operand a (acc if use_acc=1, else A).
  - OP=101 goes to MUL.
  - All other opcodes go to EXEC.
- in_ready=0 in every state except IDLE. in_valid is ignored outside IDLE.
- EXEC: lasts one cycle. Register R and ovf, then go to DONE.
  - Result: out_valid=1 after the first edge following acceptance.
- MUL: runs exactly W cycles (W edges after acceptance), then goes to DONE.
  - Multiplies magnitudes |a| and |B| into a 2W-bit unsigned product, one bit per cycle.
  - Negates the product if the operand signs differ.
  - R = low W bits of the signed product.
  - ovf=1 if the full product is outside [-2^(W-1), 2^(W-1)-1].
- DONE: out_valid=1. R and ovf are held stable while out_ready=0.
  - On an edge with out_valid=1 and out_ready=1, go to IDLE. in_ready=1 in the following cycle.
  - There is no same-cycle re-accept; throughput is at most one operation per 3 cycles.
- Opcodes:
  - 000: R = a + B.
  - 001: R = a - B.
  - 010: R = B - a.
  - 011: R = |a|.
  - 100: R = |B|.
  - 101: R = a * B.
  - 110: R = a >>> B[SW-1:0], arithmetic shift; amount is taken modulo 2^SW; ovf=0.
  - 111: clear; R=0, ovf=0.
- Add/sub: all arithmetic in W bits with wraparound. ovf = signed overflow (operand signs equal and result sign differs, after negating the subtrahend). a - B with B = -2^(W-1) follows the same rule.
- abs: operand = -2^(W-1) gives R = -2^(W-1), ovf=1. A non-negative operand passes through unchanged.
- Accumulator and sticky flag, updated on the edge that enters DONE:
  - acc <= R; ovf_sticky <= ovf_sticky | ovf.
  - Opcode 111 instead sets acc <= 0 and ovf_sticky <= 0.
- use_acc samples acc at acceptance, so chained commands see the previous result.
- Simultaneous events: rst has priority over every handshake.
- out_ready with out_valid=0 has no effect.

Test Plan:
1. W=16. OP=000, A=0x7FFF, B=0x0001, accept at edge k -> after edge k+1: out_valid=1, R=0x8000, ovf=1; once in DONE, ovf_sticky=1 and acc=0x8000.
2. OP=101, A=-3, B=7 -> out_valid rises exactly after edge k+16: R=0xFFEB, ovf=0. Then A=0x0100, B=0x0100 -> R=0x0000, ovf=1.
3. OP=011, A=0x8000 -> R=0x8000, ovf=1. OP=100, B=0xFFF6 -> R=0x000A, ovf=0. OP=110, A=0x8000, B=0x0013 -> R=0xF000 (shift of 3).
4. Backpressure: result ready, out_ready=0 for 5 cycles while in_valid pulses -> R and ovf unchanged, in_ready=0, no command accepted. out_ready=1 -> in_ready=1 in the next cycle.
5. Chain: OP=000, A=5, B=0 -> acc=5. Then use_acc=1, OP=000, B=3 -> R=8, acc=8. Then OP=111 -> R=0, acc=0, ovf_sticky=0.
6. Assert rst on the 7th cycle of MUL -> next cycle out_valid=0, in_ready=1, acc=0, ovf_sticky=0. A new OP=000 command (2+2) completes normally with R=4.
